// File: rtl/sequence_gen_serial.sv
// Serial pattern transmitter: shifts a latched SEQ_W-bit pattern out MSB first,
// repeated max(reps,1) times with GAP idle cycles between repetitions.
module sequence_gen_serial #(
   parameter int SEQ_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SEQ_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic             abort,
   output logic             data,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   localparam int BW = $clog2(SEQ_W);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [BW-1:0] BIT_MSB  = BW'(SEQ_W - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   // Handshake: start is a level sampled only while idle; no ready signal is
   // returned, busy=1 tells the requester that further starts are dropped.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [SEQ_W-1:0] pat, pat_n;
   logic [BW-1:0]    bit_idx, bit_idx_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic [GW-1:0]    gap_cnt, gap_cnt_n;
   logic             data_n, valid_n, busy_n, done_n;

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pat     <= '0;
         bit_idx <= '0;
         rem     <= '0;
         gap_cnt <= '0;
         data    <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         pat     <= pat_n;
         bit_idx <= bit_idx_n;
         rem     <= rem_n;
         gap_cnt <= gap_cnt_n;
         data    <= data_n;
         valid   <= valid_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   // rem counts repetitions still to finish; rem==0 while in SEND means the
   // last bit has gone out and this edge only raises done.
   always_comb begin
      state_n   = state;
      pat_n     = pat;
      bit_idx_n = bit_idx;
      rem_n     = rem;
      gap_cnt_n = gap_cnt;
      data_n    = 1'b0;
      valid_n   = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               pat_n     = pattern;
               rem_n     = (reps == '0) ? CNT_W'(1) : reps;
               bit_idx_n = BIT_MSB;
               busy_n    = 1'b1;
               state_n   = S_SEND;
            end
         end
         S_SEND: begin
            if (rem == '0) begin
               done_n  = 1'b1;
               state_n = S_IDLE;
            end else begin
               busy_n  = 1'b1;
               data_n  = pat[bit_idx];
               valid_n = 1'b1;
               if (bit_idx == '0) begin
                  rem_n     = rem - CNT_W'(1);
                  bit_idx_n = BIT_MSB;
                  if (rem > CNT_W'(1) && GAP > 0) begin
                     gap_cnt_n = GAP_LAST;
                     state_n   = S_GAP;
                  end
               end else begin
                  bit_idx_n = bit_idx - BW'(1);
               end
            end
         end
         S_GAP: begin
            busy_n = 1'b1;
            if (gap_cnt == '0) state_n = S_SEND;
            else gap_cnt_n = gap_cnt - GW'(1);
         end
         default: state_n = S_IDLE;
      endcase
      if (abort && state != S_IDLE) begin
         state_n = S_IDLE;
         data_n  = 1'b0;
         valid_n = 1'b0;
         busy_n  = 1'b0;
         done_n  = 1'b0;
      end
   end

endmodule

// File: tb/tb_sequence_gen_serial.sv
// Bench for sequence_gen_serial: a GAP=0 and a GAP=2 instance share inputs and
// are each checked every cycle against a queue of expected output tuples.
module tb_sequence_gen_serial;

   typedef logic [3:0] ent_q_t[$];   // entry = {data, valid, busy, done}

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [3:0] pattern;
   logic [7:0] reps;
   logic       data0, valid0, busy0, done0;
   logic       data2, valid2, busy2, done2;
   logic [1:0] st0, st2;

   int         compared = 0;
   int         mismatched = 0;
   ent_q_t     exp_q0, exp_q2;
   logic [3:0] exp0, exp2;
   string      tag;
   int         det_cnt, det_bits;
   logic [3:0] det_sh;

   always #5 clk = ~clk;

   sequence_gen_serial #(.SEQ_W(4), .CNT_W(8), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
      .abort(abort), .data(data0), .valid(valid0), .busy(busy0), .done(done0),
      .state_dbg(st0));

   sequence_gen_serial #(.SEQ_W(4), .CNT_W(8), .GAP(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
      .abort(abort), .data(data2), .valid(valid2), .busy(busy2), .done(done2),
      .state_dbg(st2));

   // Whole-transfer expectation: bits MSB first per rep, gap fillers, then done.
   function automatic ent_q_t make_xfer(input logic [3:0] p, input logic [7:0] r, input int gap);
      ent_q_t q;
      int     n;
      n = (r == 0) ? 1 : int'(r);
      for (int k = 0; k < n; k++) begin
         for (int b = 3; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
         if (k < n - 1)
            for (int g = 0; g < gap; g++) q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
      return q;
   endfunction

   function automatic void advance(input ent_q_t qi, input int gap, output ent_q_t qo,
                                   output logic [3:0] e);
      qo = qi;
      e  = 4'b0000;
      if (rst) begin
         qo.delete();
      end else if (qo.size() > 0) begin
         if (abort) qo.delete();
         else e = qo.pop_front();
      end else if (start && !abort) begin
         qo = make_xfer(pattern, reps, gap);
         e  = 4'b0010;
      end
   endfunction

   task automatic check(input string name, input logic [3:0] obs, input logic [3:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed {data,valid,busy,done}=%b expected=%b", name, obs, exp);
      end
   endtask

   task automatic tick();
      ent_q_t q;
      @(posedge clk);
      advance(exp_q0, 0, q, exp0); exp_q0 = q;
      advance(exp_q2, 2, q, exp2); exp_q2 = q;
      #1;
      check({tag, "/gap0"}, {data0, valid0, busy0, done0}, exp0);
      check({tag, "/gap2"}, {data2, valid2, busy2, done2}, exp2);
      if (valid0) begin
         det_sh = {det_sh[2:0], data0};
         det_bits++;
         if (det_bits >= 4 && det_sh == 4'b1011) det_cnt++;
      end
   endtask

   task automatic run_idle(input int max_cycles);
      int n = 0;
      while ((exp_q0.size() > 0 || exp_q2.size() > 0) && n < max_cycles) begin
         tick();
         n++;
      end
      compared++;
      assert (n < max_cycles) else begin
         mismatched++;
         $error("FAIL %s/timeout: observed cycles=%0d expected below %0d", tag, n, max_cycles);
      end
   endtask

   task automatic pulse_start(input logic [3:0] p, input logic [7:0] r);
      pattern = p;
      reps    = r;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0;
      det_cnt = 0; det_bits = 0; det_sh = '0;
      tag = "reset";
      repeat (3) tick();
      rst = 1'b0;
      tick();

      tag = "t1_single";
      pulse_start(4'b1011, 8'd1);
      run_idle(50);
      tick();

      tag = "t2_three_reps";
      det_cnt = 0; det_bits = 0; det_sh = '0;
      pulse_start(4'b1011, 8'd3);
      run_idle(100);
      compared++;
      assert (det_cnt === 3) else begin
         mismatched++;
         $error("FAIL t2_detector: observed flags=%0d expected=3", det_cnt);
      end

      tag = "t3_gap";
      pulse_start(4'b1011, 8'd2);
      run_idle(100);

      tag = "t4_reps0_ignore";
      pulse_start(4'b1101, 8'd0);
      tick();
      pulse_start(4'b0110, 8'd5);
      pattern = 4'b0000; reps = 8'd9;
      run_idle(100);

      tag = "t5_abort";
      pulse_start(4'b1011, 8'd2);
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (3) tick();

      tag = "t5_rst";
      pulse_start(4'b1111, 8'd2);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2) tick();

      tag = "idle_abort_start";
      abort = 1'b1;
      pulse_start(4'b1011, 8'd1);
      abort = 1'b0;
      repeat (2) tick();

      tag = "t6_start_in_done";
      pulse_start(4'b1001, 8'd1);
      for (int i = 0; i < 20 && exp0[0] !== 1'b1; i++) tick();
      pulse_start(4'b0111, 8'd2);
      run_idle(100);

      tag = "no_wrap_255";
      pulse_start(4'b1010, 8'd255);
      run_idle(3000);

      tag = "random";
      for (int it = 0; it < 40; it++) begin
         pulse_start(4'($urandom), 8'($urandom_range(0, 5)));
         for (int c = 0; c < 30; c++) begin
            abort = ($urandom_range(0, 40) == 0);
            start = ($urandom_range(0, 10) == 0);
            pattern = 4'($urandom);
            reps = 8'($urandom_range(0, 5));
            tick();
         end
         abort = 1'b0;
         start = 1'b0;
         run_idle(200);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
